// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract, SLICE bits per clock.
// Carry is registered between slices; results appear with a done pulse.
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   int               base;
   logic [SLICE-1:0] sa, sb, ss;
   logic [SLICE:0]   c;
   logic             last;

   // One SLICE-wide ripple chain fed by the registered carry.
   always_comb begin
      base = SLICE * int'(cnt_q);
      sa   = a_q[base +: SLICE];
      sb   = b_q[base +: SLICE];
      c    = '0;
      ss   = '0;
      c[0] = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         ss[i]   = sa[i] ^ sb[i] ^ c[i];
         c[i+1]  = (sa[i] & sb[i]) | (c[i] & (sa[i] ^ sb[i]));
      end
      last = (cnt_q == CW'(N - 1));
   end

   // Next-state, operand capture and result publishing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d[base +: SLICE] = ss;
            carry_d = c[SLICE];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               sum_d   = acc_d;
               cout_d  = c[SLICE];
               ovf_d   = c[SLICE-1] ^ c[SLICE];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: three configurations (16/4, 8/8, 8/1) checked
// against a latency/result model plus literal directed expectations.
module tb_multicycle_adder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rstn_v[3];
   logic        start_v[3];
   logic        sub_v[3];
   logic        cin_v[3];
   logic [15:0] a_v[3];
   logic [15:0] b_v[3];
   logic        busy_v[3];
   logic        done_v[3];
   logic        cout_v[3];
   logic        ovf_v[3];
   logic [15:0] sum_v[3];
   logic [15:0] sum0;
   logic [7:0]  sum1, sum2;

   assign sum_v[0] = sum0;
   assign sum_v[1] = {8'h00, sum1};
   assign sum_v[2] = {8'h00, sum2};

   multicycle_adder #(.WIDTH(16), .SLICE(4)) u0 (
      .clock(clock), .resetn(rstn_v[0]), .start(start_v[0]),
      .sub(sub_v[0]), .cin(cin_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
      .cout(cout_v[0]), .overflow(ovf_v[0]));

   multicycle_adder #(.WIDTH(8), .SLICE(8)) u1 (
      .clock(clock), .resetn(rstn_v[1]), .start(start_v[1]),
      .sub(sub_v[1]), .cin(cin_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
      .cout(cout_v[1]), .overflow(ovf_v[1]));

   multicycle_adder #(.WIDTH(8), .SLICE(1)) u2 (
      .clock(clock), .resetn(rstn_v[2]), .start(start_v[2]),
      .sub(sub_v[2]), .cin(cin_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
      .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
      .cout(cout_v[2]), .overflow(ovf_v[2]));

   int nchk = 0;
   int nerr = 0;
   logic chk_en = 1'b0;

   function automatic int wid(int k);
      return (k == 0) ? 16 : 8;
   endfunction

   function automatic int ncyc(int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
   endfunction

   task automatic chk(input string nm, input int k,
                      input logic [15:0] act, input logic [15:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[cfg%0d]: got %h expected %h", nm, k, act, exp);
      end
   endtask

   // Reference model: an accepted op yields its exact sum N edges later.
   logic        m_busy[3], m_done[3], m_cout[3], m_ovf[3];
   logic        p_cout[3], p_ovf[3];
   logic [15:0] m_sum[3], p_sum[3];
   int          m_left[3];
   logic [16:0] t_full;
   logic [15:0] t_a, t_b, t_m;
   int          t_w;

   always @(posedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (!rstn_v[k]) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_sum[k]  = 16'h0;
            m_cout[k] = 1'b0;
            m_ovf[k]  = 1'b0;
            m_left[k] = 0;
         end else if (!m_busy[k] && start_v[k]) begin
            t_w    = wid(k);
            t_m    = 16'((17'h1 << t_w) - 17'h1);
            t_a    = a_v[k] & t_m;
            t_b    = (sub_v[k] ? ~b_v[k] : b_v[k]) & t_m;
            t_full = {1'b0, t_a} + {1'b0, t_b}
                   + (sub_v[k] ? 17'd1 : {16'd0, cin_v[k]});
            p_sum[k]  = t_full[15:0] & t_m;
            p_cout[k] = t_full[t_w];
            p_ovf[k]  = (t_a[t_w-1] == t_b[t_w-1])
                     && (p_sum[k][t_w-1] != t_a[t_w-1]);
            m_busy[k] = 1'b1;
            m_done[k] = 1'b0;
            m_left[k] = ncyc(k);
         end else if (m_busy[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
               m_sum[k]  = p_sum[k];
               m_cout[k] = p_cout[k];
               m_ovf[k]  = p_ovf[k];
            end
         end else begin
            m_done[k] = 1'b0;
         end
      end
   end

   // Every cycle, every configuration: outputs must track the model.
   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk("busy", k, 16'(busy_v[k]), 16'(m_busy[k]));
            chk("done", k, 16'(done_v[k]), 16'(m_done[k]));
            chk("sum", k, sum_v[k], m_sum[k]);
            chk("cout", k, 16'(cout_v[k]), 16'(m_cout[k]));
            chk("ovf", k, 16'(ovf_v[k]), 16'(m_ovf[k]));
         end
      end
   end

   task automatic start_op(input int k, input logic s, input logic c,
                           input logic [15:0] x, input logic [15:0] y);
      sub_v[k]   = s;
      cin_v[k]   = c;
      a_v[k]     = x;
      b_v[k]     = y;
      start_v[k] = 1'b1;
      @(negedge clock);
      start_v[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, output int lat);
      lat = 0;
      while (lat < 64) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (done_v[k] === 1'b1) break;
      end
      chk("done_seen", k, 16'(done_v[k]), 16'h1);
   endtask

   task automatic dir_op(input string nm, input logic s, input logic c,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] es, input logic ec,
                         input logic eo);
      int lat;
      start_op(0, s, c, x, y);
      wait_done(0, lat);
      chk({nm, ".sum"}, 0, sum_v[0], es);
      chk({nm, ".cout"}, 0, 16'(cout_v[0]), 16'(ec));
      chk({nm, ".ovf"}, 0, 16'(ovf_v[0]), 16'(eo));
      chk({nm, ".lat"}, 0, 16'(lat), 16'd4);
   endtask

   task automatic rand_run(input int k, input int n, input int exp_lat);
      int lat;
      for (int i = 0; i < n; i++) begin
         start_op(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
         a_v[k]   = 16'($urandom);
         b_v[k]   = 16'($urandom);
         sub_v[k] = 1'($urandom_range(0, 1));
         cin_v[k] = 1'($urandom_range(0, 1));
         wait_done(k, lat);
         chk("rand.lat", k, 16'(lat), 16'(exp_lat));
         if ($urandom_range(0, 3) == 0) @(negedge clock);
      end
   endtask

   initial begin
      int lat;
      for (int k = 0; k < 3; k++) begin
         rstn_v[k]  = 1'b0;
         start_v[k] = 1'b0;
         sub_v[k]   = 1'b0;
         cin_v[k]   = 1'b0;
         a_v[k]     = 16'h0;
         b_v[k]     = 16'h0;
      end
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      chk("rst.busy", 0, 16'(busy_v[0]), 16'h0);
      chk("rst.done", 0, 16'(done_v[0]), 16'h0);
      chk("rst.sum", 0, sum_v[0], 16'h0);
      for (int k = 0; k < 3; k++) rstn_v[k] = 1'b1;
      @(negedge clock);

      dir_op("add1", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
      @(negedge clock);
      chk("add1.pulse", 0, 16'(done_v[0]), 16'h0);
      dir_op("wrap", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      dir_op("povf", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
      dir_op("cin", 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0);
      dir_op("sub1", 1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
      dir_op("sub2", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

      start_op(0, 1'b0, 1'b0, 16'h1111, 16'h2222);
      a_v[0]     = 16'hFFFF;
      b_v[0]     = 16'hFFFF;
      sub_v[0]   = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clock);
      start_v[0] = 1'b0;
      a_v[0]     = 16'h0F0F;
      wait_done(0, lat);
      chk("rob.sum", 0, sum_v[0], 16'h3333);
      chk("rob.lat", 0, 16'(lat), 16'd3);
      @(negedge clock);
      chk("rob.idle", 0, 16'(busy_v[0]), 16'h0);

      start_op(0, 1'b0, 1'b0, 16'h0001, 16'h0002);
      wait_done(0, lat);
      start_v[0] = 1'b1;
      sub_v[0]   = 1'b0;
      cin_v[0]   = 1'b0;
      a_v[0]     = 16'h0100;
      b_v[0]     = 16'h0200;
      @(negedge clock);
      start_v[0] = 1'b0;
      chk("b2b.busy", 0, 16'(busy_v[0]), 16'h1);
      chk("b2b.done", 0, 16'(done_v[0]), 16'h0);
      wait_done(0, lat);
      chk("b2b.sum", 0, sum_v[0], 16'h0300);
      chk("b2b.lat", 0, 16'(lat), 16'd4);

      start_op(0, 1'b0, 1'b0, 16'h1111, 16'h2222);
      @(negedge clock);
      rstn_v[0] = 1'b0;
      @(negedge clock);
      rstn_v[0] = 1'b1;
      chk("abort.busy", 0, 16'(busy_v[0]), 16'h0);
      chk("abort.sum", 0, sum_v[0], 16'h0);
      chk("abort.cout", 0, 16'(cout_v[0]), 16'h0);
      chk("abort.ovf", 0, 16'(ovf_v[0]), 16'h0);
      repeat (6) begin
         @(negedge clock);
         chk("abort.nodone", 0, 16'(done_v[0]), 16'h0);
      end
      dir_op("after", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);

      rand_run(0, 64, 4);
      rand_run(1, 256, 1);
      rand_run(2, 256, 8);

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nerr);
      $finish;
   end

endmodule
